// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter (fetch port vs data port).
package sram_arbiter_pkg;

  typedef enum logic { ST_IDLE = 1'b0, ST_BUSY = 1'b1 } state_t;
  typedef enum logic { OWN_IF = 1'b0, OWN_D = 1'b1 } owner_t;
  typedef enum logic [1:0] { PICK_NONE = 2'd0, PICK_IF = 2'd1, PICK_D = 2'd2 } pick_t;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;
  // Wide enough for the largest legal read latency (4).
  localparam int CNT_W          = 3;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the arbiter.
// slave = arbiter view, master = core/memory environment view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_stall_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [3:0]        d_sel_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_stall_o;

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [3:0]        mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
    input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_stall_o,
    output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
    output d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_stall_o,
    input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner selection: data first until it has starved fetch
// STARVE_MAX times, then fetch (unless flushed), then data as fallback.
module sram_arb_pick
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          free,
  input  logic          if_req,
  input  logic          if_flush,
  input  logic          d_req,
  input  logic [SW-1:0] starve,
  output pick_t         pick
);

  always_comb begin
    pick = PICK_NONE;
    if (free) begin
      if (d_req && (starve < SW'(STARVE_MAX))) pick = PICK_D;
      else if (if_req && !if_flush)            pick = PICK_IF;
      else if (d_req)                          pick = PICK_D;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data ports.
// Optional build macro ARB_PERF_CNT_EN adds saturating per-port stall-cycle counters.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_if_wait_o,
  output logic [31:0]   perf_d_wait_o
`endif
);

  localparam int              SW  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_t           owner_q, owner_d;
  logic             killed_q, killed_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic  expiring, free, kill_now, rd_grant, if_rv, d_rv;
  pick_t pick;

  assign expiring = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
  assign free     = (state_q == ST_IDLE) || expiring;
  // A flush in the returning cycle itself must already hide the fetch data.
  assign kill_now = (owner_q == OWN_IF) && (killed_q || bus.if_flush_i);
  assign rd_grant = (pick == PICK_IF) || ((pick == PICK_D) && !bus.d_we_i);

  sram_arb_pick #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_pick (
    .free     (free),
    .if_req   (bus.if_req_i),
    .if_flush (bus.if_flush_i),
    .d_req    (bus.d_req_i),
    .starve   (starve_q),
    .pick     (pick)
  );

  // NOTE: state uses non-blocking assignments; the reset is synchronous, so it is just the first branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      owner_q  <= OWN_IF;
      killed_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no branch can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    killed_d = killed_q;
    starve_d = starve_q;

    if (rd_grant) begin
      state_d  = ST_BUSY;
      cnt_d    = LAT;
      owner_d  = (pick == PICK_D) ? OWN_D : OWN_IF;
      killed_d = 1'b0;
    end else if ((state_q == ST_BUSY) && !expiring) begin
      cnt_d    = cnt_q - CNT_W'(1);
      killed_d = kill_now;
    end else begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      killed_d = 1'b0;
    end

    if (!bus.if_req_i || (pick == PICK_IF))                  starve_d = '0;
    else if ((pick == PICK_D) && (starve_q < SW'(STARVE_MAX))) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    bus.if_gnt_o    = (pick == PICK_IF);
    bus.d_gnt_o     = (pick == PICK_D);
    bus.mem_ce_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_sel_o   = 4'h0;
    bus.mem_addr_o  = {ADDR_W{1'b0}};
    bus.mem_wdata_o = {DATA_W{1'b0}};
    case (pick)
      PICK_IF: begin
        bus.mem_ce_o   = 1'b1;
        bus.mem_sel_o  = 4'hF;
        bus.mem_addr_o = bus.if_addr_i;
      end
      PICK_D: begin
        bus.mem_ce_o    = 1'b1;
        bus.mem_we_o    = bus.d_we_i;
        bus.mem_sel_o   = bus.d_sel_i;
        bus.mem_addr_o  = bus.d_addr_i;
        bus.mem_wdata_o = bus.d_wdata_i;
      end
      default: ;
    endcase

    if_rv           = expiring && (owner_q == OWN_IF) && !kill_now;
    d_rv            = expiring && (owner_q == OWN_D);
    bus.if_rvalid_o = if_rv;
    bus.d_rvalid_o  = d_rv;
    bus.if_rdata_o  = if_rv ? bus.mem_rdata_i : {DATA_W{1'b0}};
    bus.d_rdata_o   = d_rv  ? bus.mem_rdata_i : {DATA_W{1'b0}};
    bus.if_stall_o  = (bus.if_req_i && (pick != PICK_IF)) ||
                      ((state_q == ST_BUSY) && (owner_q == OWN_IF) && !kill_now && !if_rv);
    bus.d_stall_o   = (bus.d_req_i && (pick != PICK_D)) ||
                      ((state_q == ST_BUSY) && (owner_q == OWN_D) && !d_rv);
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_wait_o <= '0;
      perf_d_wait_o  <= '0;
    end else begin
      if (bus.if_stall_o && (perf_if_wait_o != '1)) perf_if_wait_o <= perf_if_wait_o + 32'd1;
      if (bus.d_stall_o  && (perf_d_wait_o  != '1)) perf_d_wait_o  <= perf_d_wait_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three DUT lanes (MEM_LAT = 1, 2, 3), each with an SRAM model and a
// transaction-level reference checked every cycle, plus directed scenarios with literal expectations.
module tb_sram_arbiter;

  localparam int NL = 3;
  localparam int SM = 4;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } stim_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic        if_stall;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_stall;
    logic [31:0] d_rdata;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_fail = 0;
  bit    chk_en = 1'b0;
  stim_t stim [NL];
  resp_t resp [NL];
  string b_pat = "DDDDIDDDDI";

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int LAT = g + 1;

    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if, perf_d;
    int m_pi, m_pd;
`endif

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_if_wait_o (perf_if),
      .perf_d_wait_o  (perf_d)
`endif
    );

    assign bus.if_req_i   = stim[g].if_req;
    assign bus.if_addr_i  = stim[g].if_addr;
    assign bus.if_flush_i = stim[g].if_flush;
    assign bus.d_req_i    = stim[g].d_req;
    assign bus.d_we_i     = stim[g].d_we;
    assign bus.d_sel_i    = stim[g].d_sel;
    assign bus.d_addr_i   = stim[g].d_addr;
    assign bus.d_wdata_i  = stim[g].d_wdata;

    assign resp[g] = {bus.if_gnt_o, bus.if_rvalid_o, bus.if_stall_o, bus.if_rdata_o,
                      bus.d_gnt_o, bus.d_rvalid_o, bus.d_stall_o, bus.d_rdata_o,
                      bus.mem_ce_o, bus.mem_we_o, bus.mem_sel_o, bus.mem_addr_o, bus.mem_wdata_o};

    // Synchronous SRAM, word i preloaded with 0x1000_0000 + 4*i; read data appears LAT cycles later.
    logic [31:0] sram [256];
    logic [31:0] pipe [LAT];
    assign bus.mem_rdata_i = pipe[LAT-1];

    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      if (bus.mem_ce_o && !bus.mem_we_o) pipe[0] <= sram[bus.mem_addr_o[9:2]];
      if (rst) begin
        for (int i = 0; i < 256; i++) sram[i] <= 32'h1000_0000 + 32'(i * 4);
      end else if (bus.mem_ce_o && bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_sel_o[b]) sram[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end
    end

    // Reference: at most one outstanding read, described by owner, due cycle, kill flag and the
    // word it must return; memory contents tracked separately from the SRAM model.
    bit          m_out, m_own_d, m_killed;
    int          m_due, m_starve;
    logic [31:0] m_data;
    logic [31:0] ref_mem [256];
    stim_t       s;
    bit          ret, fr, gi, gd, kn, e_ifv, e_dv, e_ifs, e_ds;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_sel;

    always @(negedge clk) begin
      s   = stim[g];
      ret = m_out && (cyc == m_due);
      fr  = !m_out || ret;
      gi  = 1'b0;
      gd  = 1'b0;
      if (fr) begin
        if (s.d_req && m_starve < SM)  gd = 1'b1;
        else if (s.if_req && !s.if_flush) gi = 1'b1;
        else if (s.d_req)              gd = 1'b1;
      end
      kn     = m_out && !m_own_d && (m_killed || s.if_flush);
      e_ifv  = ret && !m_own_d && !kn;
      e_dv   = ret && m_own_d;
      e_ifs  = (s.if_req && !gi) || (m_out && !m_own_d && !kn && !e_ifv);
      e_ds   = (s.d_req && !gd) || (m_out && m_own_d && !e_dv);
      e_addr = gi ? s.if_addr : (gd ? s.d_addr : 32'h0);
      e_sel  = gi ? 4'hF : (gd ? s.d_sel : 4'h0);
      e_wd   = gd ? s.d_wdata : 32'h0;

      if (chk_en) begin
        check($sformatf("L%0d handshake", g),
              {resp[g].if_gnt, resp[g].if_rvalid, resp[g].if_stall, resp[g].d_gnt, resp[g].d_rvalid, resp[g].d_stall},
              {gi, e_ifv, e_ifs, gd, e_dv, e_ds});
        check($sformatf("L%0d mem ctl", g), {resp[g].mem_ce, resp[g].mem_we, resp[g].mem_sel},
              {gi | gd, gd & s.d_we, e_sel});
        check($sformatf("L%0d mem addr", g), resp[g].mem_addr, e_addr);
        check($sformatf("L%0d mem wdata", g), resp[g].mem_wdata, e_wd);
        check($sformatf("L%0d if rdata", g), resp[g].if_rdata, e_ifv ? m_data : 32'h0);
        check($sformatf("L%0d d rdata", g), resp[g].d_rdata, e_dv ? m_data : 32'h0);
`ifdef ARB_PERF_CNT_EN
        check($sformatf("L%0d perf if", g), perf_if, 32'(m_pi));
        check($sformatf("L%0d perf d", g), perf_d, 32'(m_pd));
`endif
      end

      if (rst) begin
        m_out    = 1'b0;
        m_killed = 1'b0;
        m_starve = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + 32'(i * 4);
`ifdef ARB_PERF_CNT_EN
        m_pi = 0;
        m_pd = 0;
`endif
      end else begin
`ifdef ARB_PERF_CNT_EN
        if (e_ifs) m_pi++;
        if (e_ds)  m_pd++;
`endif
        if (!s.if_req || gi)           m_starve = 0;
        else if (gd && m_starve < SM)  m_starve++;
        if (gd && s.d_we)
          for (int b = 0; b < 4; b++)
            if (s.d_sel[b]) ref_mem[s.d_addr[9:2]][8*b +: 8] = s.d_wdata[8*b +: 8];
        if (gi || (gd && !s.d_we)) begin
          m_out    = 1'b1;
          m_own_d  = gd;
          m_due    = cyc + LAT;
          m_killed = 1'b0;
          m_data   = ref_mem[e_addr[9:2]];
        end else if (ret) begin
          m_out = 1'b0;
        end else if (kn) begin
          m_killed = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int l = 0; l < NL; l++) stim[l] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset L1 outputs", resp[1], '0);
    check("reset L2 ctl", {resp[2].if_gnt, resp[2].d_gnt, resp[2].mem_ce, resp[2].if_stall}, 4'b0);

    // Fetch stream at latency 1, then a flushed request that must not be granted.
    step(); stim[0].if_req = 1'b1; stim[0].if_addr = 32'h0;
    @(negedge clk);
    check("A gnt0", resp[0].if_gnt, 1'b1);
    check("A stall0", resp[0].if_stall, 1'b0);
    step(); stim[0].if_addr = 32'h4;
    @(negedge clk);
    check("A gnt1", resp[0].if_gnt, 1'b1);
    check("A data0", resp[0].if_rdata, 32'h1000_0000);
    step(); stim[0].if_addr = 32'h8;
    @(negedge clk);
    check("A data1", resp[0].if_rdata, 32'h1000_0004);
    check("A stall2", resp[0].if_stall, 1'b0);
    step(); stim[0].if_req = 1'b0;
    @(negedge clk);
    check("A data2", {resp[0].if_rvalid, resp[0].if_rdata}, {1'b1, 32'h1000_0008});
    step(); stim[0].if_req = 1'b1; stim[0].if_flush = 1'b1; stim[0].if_addr = 32'hC;
    @(negedge clk);
    check("A flushed req", {resp[0].if_gnt, resp[0].if_stall, resp[0].mem_ce}, 3'b010);
    step(); stim[0] = '0;

    // Both ports requesting continuously: starvation limit forces every fifth grant to fetch.
    step();
    stim[0].if_req = 1'b1; stim[0].if_addr = 32'h80;
    stim[0].d_req = 1'b1; stim[0].d_sel = 4'hF; stim[0].d_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      @(negedge clk);
      check($sformatf("B d_gnt[%0d]", i), resp[0].d_gnt, b_pat[i] == "D");
      check($sformatf("B if_gnt[%0d]", i), resp[0].if_gnt, b_pat[i] == "I");
      check($sformatf("B if_stall[%0d]", i), resp[0].if_stall, b_pat[i] == "D");
    end
    step(); stim[0] = '0;
    step();

    // Latency 3: data load with a pending fetch; fetch wins the returning cycle.
    step();
    stim[2].d_req = 1'b1; stim[2].d_sel = 4'hF; stim[2].d_addr = 32'h100;
    stim[2].if_req = 1'b1; stim[2].if_addr = 32'h0;
    @(negedge clk);
    check("C d_gnt", {resp[2].d_gnt, resp[2].if_gnt}, 2'b10);
    step(); stim[2].d_req = 1'b0;
    @(negedge clk);
    check("C wait1", {resp[2].d_stall, resp[2].d_rvalid, resp[2].if_stall}, 3'b101);
    step();
    @(negedge clk);
    check("C wait2", {resp[2].d_stall, resp[2].d_rvalid, resp[2].if_gnt}, 3'b100);
    step();
    @(negedge clk);
    check("C return", {resp[2].d_rvalid, resp[2].d_stall, resp[2].if_gnt}, 3'b101);
    check("C rdata", resp[2].d_rdata, 32'h1000_0100);
    step(); stim[2].if_req = 1'b0;
    step();
    step();
    @(negedge clk);
    check("C fetch data", {resp[2].if_rvalid, resp[2].if_rdata}, {1'b1, 32'h1000_0000});
    step();

    // Latency 2: flushed fetch returns nothing; next fetch proceeds normally.
    step(); stim[1].if_req = 1'b1; stim[1].if_addr = 32'h10;
    @(negedge clk);
    check("D gnt", resp[1].if_gnt, 1'b1);
    step(); stim[1].if_req = 1'b0; stim[1].if_flush = 1'b1;
    @(negedge clk);
    check("D flush cyc", {resp[1].if_rvalid, resp[1].if_stall, resp[1].mem_ce}, 3'b000);
    step(); stim[1].if_flush = 1'b0; stim[1].if_req = 1'b1; stim[1].if_addr = 32'h14;
    @(negedge clk);
    check("D killed ret", {resp[1].if_rvalid, resp[1].if_gnt, resp[1].mem_ce}, 3'b011);
    step(); stim[1].if_req = 1'b0;
    step();
    @(negedge clk);
    check("D next data", {resp[1].if_rvalid, resp[1].if_rdata}, {1'b1, 32'h1000_0014});
    step();

    // Partial write followed by a load of the same word.
    step();
    stim[0].d_req = 1'b1; stim[0].d_we = 1'b1; stim[0].d_sel = 4'b0011;
    stim[0].d_addr = 32'h200; stim[0].d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("E write ctl", {resp[0].d_gnt, resp[0].mem_we, resp[0].mem_sel}, 6'b110011);
    check("E write data", resp[0].mem_wdata, 32'hDEAD_BEEF);
    step(); stim[0].d_we = 1'b0; stim[0].d_sel = 4'hF; stim[0].d_wdata = 32'h0;
    @(negedge clk);
    check("E no wr rvalid", {resp[0].d_gnt, resp[0].d_rvalid, resp[0].mem_we}, 3'b100);
    step(); stim[0] = '0;
    @(negedge clk);
    check("E merged", {resp[0].d_rvalid, resp[0].d_rdata}, {1'b1, 32'h1000_BEEF});
    step();

    // Reset while a latency-2 load is outstanding with two cycles left.
    step(); stim[1].d_req = 1'b1; stim[1].d_sel = 4'hF; stim[1].d_addr = 32'h300;
    @(negedge clk);
    check("F gnt", resp[1].d_gnt, 1'b1);
    step(); stim[1] = '0; rst = 1'b1;
    @(negedge clk);
    check("F busy stall", resp[1].d_stall, 1'b1);
    step(); rst = 1'b0;
    @(negedge clk);
    check("F after reset", resp[1], '0);
    step();
    @(negedge clk);
    check("F no late rvalid", {resp[1].d_rvalid, resp[1].d_stall}, 2'b00);
    repeat (3) step();

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
